// File: rtl/pipeline_stall_controller.sv
// Stall/flush controller that sits beside the fetch stage.
// Drives the PC register's 2-bit nop command and the IF/ID and ID/EX
// hold/flush/bubble strobes in the same cycle as the hazard, branch or
// memory-busy event. Also keeps a saturating count of stalled cycles.
module pipeline_stall_controller #(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int MEM_WAIT_MAX        = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [3:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic [1:0]  pc_nop,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, FLUSH} state_t;
  // What the pipeline is told to do this cycle, after priority resolution.
  typedef enum logic [1:0] {ACT_NONE, ACT_LU, ACT_FLUSH, ACT_MEM} act_t;

  localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] BR_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(MEM_WAIT_MAX);

  state_t      state_reg, state_next;
  logic [2:0]  rem_reg, rem_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        mem_timeout_reg, mem_timeout_next;
  logic        ignore_busy_reg, ignore_busy_next;
  logic [15:0] stall_count_reg;

  logic        lu;
  logic        busy;
  state_t      eff_state;
  act_t        act;
  logic [7:0]  wait_inc;

  // Hazard decode, effective state and priority-resolved action
  always_comb begin
    lu = ex_mem_read && (ex_rd != 4'd0) &&
         ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    // After a timeout, a still-high mem_busy is disregarded until it drops.
    busy = mem_busy && !ignore_busy_reg;
    // Leaving MEM_WAIT, the same cycle is handled as the state it interrupted;
    // a non-zero rem means a load stall was preempted.
    eff_state = state_reg;
    if (state_reg == MEM_WAIT && !busy)
      eff_state = (rem_reg != 3'd0) ? LOAD_STALL : RUN;
    act = ACT_NONE;
    if (busy)
      act = ACT_MEM;
    else if (branch_taken || eff_state == FLUSH)
      act = ACT_FLUSH;
    else if (lu || eff_state == LOAD_STALL)
      act = ACT_LU;
    wait_inc = (state_reg == MEM_WAIT) ? wait_cnt_reg + 8'd1 : 8'd1;
  end

  // Next-state and counter update logic
  always_comb begin
    state_next       = RUN;
    rem_next         = 3'd0;
    wait_cnt_next    = 8'd0;
    mem_timeout_next = mem_timeout_reg;
    ignore_busy_next = ignore_busy_reg && mem_busy;
    case (act)
      ACT_MEM: begin
        if (wait_inc >= WAIT_MAX) begin
          mem_timeout_next = 1'b1;
          ignore_busy_next = 1'b1;
        end else begin
          state_next    = MEM_WAIT;
          wait_cnt_next = wait_inc;
          // Keep the outstanding load-stall count so it resumes afterwards.
          if (state_reg == LOAD_STALL || state_reg == MEM_WAIT)
            rem_next = rem_reg;
        end
      end
      ACT_FLUSH: begin
        if (branch_taken) begin
          if (BRANCH_FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            rem_next   = BR_RELOAD;
          end
        end else if (rem_reg > 3'd1) begin
          state_next = FLUSH;
          rem_next   = rem_reg - 3'd1;
        end
      end
      ACT_LU: begin
        if (eff_state == LOAD_STALL) begin
          if (rem_reg > 3'd1) begin
            state_next = LOAD_STALL;
            rem_next   = rem_reg - 3'd1;
          end
        end else if (LOAD_STALL_CYCLES > 1) begin
          state_next = LOAD_STALL;
          rem_next   = LS_RELOAD;
        end
      end
      default: ;
    endcase
  end

  // Mealy outputs, forced quiet while reset is asserted
  always_comb begin
    pc_nop       = 2'b00;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!reset) begin
      case (act)
        ACT_MEM: begin
          pc_nop      = 2'b10;
          if_id_hold  = 1'b1;
          pipe_freeze = 1'b1;
        end
        ACT_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        ACT_LU: begin
          pc_nop       = 2'b01;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State, counters and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      rem_reg         <= 3'd0;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
      ignore_busy_reg <= 1'b0;
      stall_count_reg <= 16'd0;
    end else begin
      state_reg       <= state_next;
      rem_reg         <= rem_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
      ignore_busy_reg <= ignore_busy_next;
      if (pc_nop != 2'b00 && stall_count_reg != 16'hFFFF)
        stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign mem_timeout = mem_timeout_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: one DUT with default parameters and
// one with LOAD_STALL_CYCLES = 3 share the same stimulus. Vectors carry the
// expected outputs; they are queued when driven and checked at the falling edge.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;

  logic [1:0]  a_pc_nop, b_pc_nop;
  logic        a_hold, a_flush, a_bubble, a_freeze, a_to;
  logic        b_hold, b_flush, b_bubble, b_freeze, b_to;
  logic [15:0] a_cnt, b_cnt;

  // expected output bundle: {pc_nop, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [5:0] E_NONE = 6'b00_0000;
  localparam logic [5:0] E_LU   = 6'b01_1010;
  localparam logic [5:0] E_BR   = 6'b00_0110;
  localparam logic [5:0] E_MEM  = 6'b10_1001;

  typedef struct {
    logic        rst;
    logic [3:0]  rs1, rs2, rd;
    logic        u1, u2, mr, bt, mb;
    logic        sel;      // 0: default DUT, 1: three-cycle load-stall DUT
    logic [5:0]  ex;
    logic        to;
    int          cnt;      // expected stall_count, -1 = not checked
    logic [63:0] nm;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller dut_a (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_nop(a_pc_nop), .if_id_hold(a_hold), .if_id_flush(a_flush), .id_ex_bubble(a_bubble),
    .pipe_freeze(a_freeze), .mem_timeout(a_to), .stall_count(a_cnt)
  );

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_nop(b_pc_nop), .if_id_hold(b_hold), .if_id_flush(b_flush), .id_ex_bubble(b_bubble),
    .pipe_freeze(b_freeze), .mem_timeout(b_to), .stall_count(b_cnt)
  );

  // mode: 0 idle, 1 hazard via rs1, 2 hazard via rs2, 3 ex_rd = 0,
  //       4 match but sources unused, 5 match but not a load
  function automatic vec_t mkv(input logic rst, input int mode, input logic bt, input logic mb,
                               input logic sel, input logic [5:0] ex, input logic to,
                               input int cnt, input logic [63:0] nm);
    vec_t v;
    v.rst = rst; v.bt = bt; v.mb = mb; v.sel = sel; v.ex = ex; v.to = to; v.cnt = cnt; v.nm = nm;
    v.rs1 = 4'd5; v.rs2 = 4'd6; v.rd = 4'd3; v.u1 = 1'b1; v.u2 = 1'b1; v.mr = 1'b0;
    case (mode)
      1: begin v.mr = 1'b1; v.rs1 = 4'd3; end
      2: begin v.mr = 1'b1; v.rs2 = 4'd3; end
      3: begin v.mr = 1'b1; v.rd = 4'd0; v.rs1 = 4'd0; end
      4: begin v.mr = 1'b1; v.rs1 = 4'd3; v.rs2 = 4'd3; v.u1 = 1'b0; v.u2 = 1'b0; end
      5: begin v.rs1 = 4'd3; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; ex_mem_read = v.mr;
    branch_taken = v.bt; mem_busy = v.mb;
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    sb.push_back(v);
  endtask

  // Scoreboard checker: one line per transaction
  always @(negedge clk) begin : chk
    vec_t e;
    logic [5:0] act;
    logic to_act;
    logic [15:0] cnt_act;
    logic bad;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act     = e.sel ? {b_pc_nop, b_hold, b_flush, b_bubble, b_freeze}
                      : {a_pc_nop, a_hold, a_flush, a_bubble, a_freeze};
      to_act  = e.sel ? b_to : a_to;
      cnt_act = e.sel ? b_cnt : a_cnt;
      bad = 1'b0;
      tests++;
      if (act !== e.ex || to_act !== e.to) begin fails++; bad = 1'b1; end
      if (e.cnt >= 0) begin
        tests++;
        if (cnt_act !== 16'(e.cnt)) begin fails++; bad = 1'b1; end
      end
      if (bad)
        $display("FAIL %s: got out=%b to=%b cnt=%0d, expected out=%b to=%b cnt=%0d",
                 e.nm, act, to_act, cnt_act, e.ex, e.to, e.cnt);
      else
        $display("[TB] ok %s out=%b to=%b cnt=%0d", e.nm, act, to_act, cnt_act);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // -------- table: {inputs, expected outputs} --------
    // default DUT: load-use detection and negative cases
    tbl.push_back(mkv(1, 1, 0, 0, 0, E_NONE, 0,  0, "rst_a"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  0, "idle"));
    tbl.push_back(mkv(0, 1, 0, 0, 0, E_LU,   0,  0, "lu_rs1"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  1, "lu_end"));
    tbl.push_back(mkv(0, 3, 0, 0, 0, E_NONE, 0,  1, "rd_zero"));
    tbl.push_back(mkv(0, 2, 0, 0, 0, E_LU,   0,  1, "lu_rs2"));
    tbl.push_back(mkv(0, 4, 0, 0, 0, E_NONE, 0,  2, "unused"));
    tbl.push_back(mkv(0, 5, 0, 0, 0, E_NONE, 0,  2, "no_load"));
    // taken branch beats a simultaneous load-use; two flush cycles
    tbl.push_back(mkv(0, 1, 1, 0, 0, E_BR,   0,  2, "br_lu"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_BR,   0,  2, "br_2nd"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  2, "br_end"));
    // second branch during FLUSH reloads the flush length
    tbl.push_back(mkv(0, 0, 1, 0, 0, E_BR,   0, -1, "br_a"));
    tbl.push_back(mkv(0, 0, 1, 0, 0, E_BR,   0, -1, "br_reld"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_BR,   0, -1, "br_tail"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  2, "br_done"));
    // memory wait, then busy beats branch, then branch applied on release
    tbl.push_back(mkv(0, 0, 0, 1, 0, E_MEM,  0,  2, "mem1"));
    tbl.push_back(mkv(0, 0, 0, 1, 0, E_MEM,  0,  3, "mem2"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  4, "mem_rel"));
    tbl.push_back(mkv(0, 0, 1, 1, 0, E_MEM,  0,  4, "mem_br"));
    tbl.push_back(mkv(0, 0, 1, 0, 0, E_BR,   0,  5, "rel_br"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_BR,   0,  5, "rel_br2"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  5, "rel_end"));
    // three-cycle load stall with the hazard held
    tbl.push_back(mkv(1, 0, 0, 0, 1, E_NONE, 0, -1, "rst_b"));
    tbl.push_back(mkv(0, 1, 0, 0, 1, E_LU,   0,  0, "ls3_1"));
    tbl.push_back(mkv(0, 1, 0, 0, 1, E_LU,   0,  1, "ls3_2"));
    tbl.push_back(mkv(0, 1, 0, 0, 1, E_LU,   0,  2, "ls3_3"));
    tbl.push_back(mkv(0, 0, 0, 0, 1, E_NONE, 0,  3, "ls3_end"));
    // mem_busy for 4 cycles on the second load-stall cycle
    tbl.push_back(mkv(1, 0, 0, 0, 1, E_NONE, 0, -1, "rst_b2"));
    tbl.push_back(mkv(0, 1, 0, 0, 1, E_LU,   0,  0, "lsm_lu"));
    tbl.push_back(mkv(0, 0, 0, 1, 1, E_MEM,  0,  1, "lsm_m1"));
    tbl.push_back(mkv(0, 0, 0, 1, 1, E_MEM,  0,  2, "lsm_m2"));
    tbl.push_back(mkv(0, 0, 0, 1, 1, E_MEM,  0,  3, "lsm_m3"));
    tbl.push_back(mkv(0, 0, 0, 1, 1, E_MEM,  0,  4, "lsm_m4"));
    tbl.push_back(mkv(0, 0, 0, 0, 1, E_LU,   0,  5, "lsm_r1"));
    tbl.push_back(mkv(0, 0, 0, 0, 1, E_LU,   0,  6, "lsm_r2"));
    tbl.push_back(mkv(0, 0, 0, 0, 1, E_NONE, 0,  7, "lsm_end"));
    // reset in the middle of FLUSH
    tbl.push_back(mkv(1, 0, 0, 0, 0, E_NONE, 0, -1, "rst_a2"));
    tbl.push_back(mkv(0, 1, 0, 0, 0, E_LU,   0,  0, "rf_lu"));
    tbl.push_back(mkv(0, 0, 1, 0, 0, E_BR,   0,  1, "rf_br"));
    tbl.push_back(mkv(1, 0, 0, 0, 0, E_NONE, 0, -1, "rf_rst"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  0, "rf_aft1"));
    tbl.push_back(mkv(0, 0, 0, 0, 0, E_NONE, 0,  0, "rf_aft2"));
    // reset in the middle of LOAD_STALL
    tbl.push_back(mkv(1, 0, 0, 0, 1, E_NONE, 0, -1, "rst_b3"));
    tbl.push_back(mkv(0, 1, 0, 0, 1, E_LU,   0,  0, "rl_lu"));
    tbl.push_back(mkv(1, 0, 0, 0, 1, E_NONE, 0, -1, "rl_rst"));
    tbl.push_back(mkv(0, 0, 0, 0, 1, E_NONE, 0,  0, "rl_aft1"));
    tbl.push_back(mkv(0, 0, 0, 0, 1, E_NONE, 0,  0, "rl_aft2"));

    // power-up reset before the table starts
    drive(mkv(1, 0, 0, 0, 0, E_NONE, 0, -1, "pwr"));
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // -------- memory timeout: mem_busy held for 20 cycles --------
    apply(mkv(1, 0, 0, 0, 0, E_NONE, 0, -1, "to_rst"));
    for (int i = 1; i <= 20; i++)
      apply(mkv(0, 0, 0, 1, 0, (i <= 15) ? E_MEM : E_NONE, (i > 15) ? 1'b1 : 1'b0,
                (i == 1) ? 0 : ((i == 16) ? 15 : -1), (i <= 15) ? "to_wait" : "to_ign"));
    apply(mkv(0, 0, 0, 0, 0, E_NONE, 1, 15, "to_drop"));
    apply(mkv(0, 0, 0, 1, 0, E_MEM,  1, 15, "to_rebsy"));
    apply(mkv(0, 0, 0, 0, 0, E_NONE, 1, 16, "to_stick"));
    apply(mkv(1, 0, 0, 0, 0, E_NONE, 1, -1, "to_clr"));
    apply(mkv(0, 0, 0, 0, 0, E_NONE, 0,  0, "to_gone"));

    // -------- stall counter saturation --------
    apply(mkv(1, 0, 0, 0, 0, E_NONE, 0, -1, "sat_rst"));
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk); #1;
      drive(mkv(0, 1, 0, 0, 0, E_LU, 0, -1, "sat"));
    end
    apply(mkv(0, 0, 0, 0, 0, E_NONE, 0, 65535, "sat_top"));
    apply(mkv(0, 1, 0, 0, 0, E_LU,   0, 65535, "sat_lu"));
    apply(mkv(0, 0, 0, 0, 0, E_NONE, 0, 65535, "sat_hold"));

    @(negedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
